// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a capture/execute/respond
// sequence, with round-robin arbitration when both requesters are pending.

// ALU: 2-bit op selects add, subtract, AND or XOR. For add and subtract,
// cout is bit W of the zero-extended result. For subtract this bit is the
// borrow. For the logic ops, cout is 0.
module ALU #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] out,
    output logic         cout
);

    logic [W:0] res;

    // Result is formed one bit wider than the operands so the carry/borrow falls out.
    always_comb begin
        res = '0;
        case (op)
            2'b00:   res = {1'b0, a} + {1'b0, b};
            2'b01:   res = {1'b0, a} - {1'b0, b};
            2'b10:   res = {1'b0, a & b};
            default: res = {1'b0, a ^ b};
        endcase
    end

    assign out  = res[W-1:0];
    assign cout = res[W];

endmodule

module alu_arbiter #(
    parameter int W     = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [1:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [1:0]       req1_op,
    output logic             req1_ready,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [W-1:0]     rsp_out,
    output logic             rsp_cout,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           prio;
    logic           owner;
    logic           grant;
    logic           accept;
    logic           rsp_hs;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [1:0]     op_q;
    logic [W-1:0]   alu_out;
    logic           alu_cout;

    // A lone requester always wins. When both or neither are pending, prio decides.
    always_comb begin
        grant = prio;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    // rst_n gates ready so that no requester sees acceptance while reset is held.
    assign req0_ready = (state == IDLE) & ~grant & rst_n;
    assign req1_ready = (state == IDLE) &  grant & rst_n;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign rsp0_valid = (state == RESP) & ~owner;
    assign rsp1_valid = (state == RESP) &  owner;
    assign rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: capture, execute for one cycle, then hold until the owner takes the result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: owner, round-robin priority, busy flag and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 1'b0;
            prio     <= 1'b0;
            busy     <= 1'b0;
            ops_done <= '0;
        end else begin
            if (accept) begin
                owner <= grant;
                busy  <= 1'b1;
            end else if (rsp_hs) begin
                busy <= 1'b0;
            end
            if (rsp_hs) begin
                prio     <= ~owner;
                ops_done <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Operand capture on acceptance. These are data registers only, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= grant ? req1_a  : req0_a;
            b_q  <= grant ? req1_b  : req0_b;
            op_q <= grant ? req1_op : req0_op;
        end
    end

    ALU #(.W(W)) u_alu (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .out  (alu_out),
        .cout (alu_cout)
    );

    // Result register is loaded at the end of EXEC and held through RESP. It clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_out  <= '0;
            rsp_cout <= 1'b0;
        end else if (state == EXEC) begin
            rsp_out  <= alu_out;
            rsp_cout <= alu_cout;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. The expected ALU results are computed by hand:
// add/sub yield a 7-bit result whose top bit is cout, and the logic ops give cout = 0.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [5:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [5:0] rsp_out;
    logic       rsp_cout;
    logic       busy;
    logic [7:0] ops_done;

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter #(.W(6), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_out    (rsp_out),
        .rsp_cout   (rsp_cout),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int served;
        int who;
        int n;

        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ops_done", ops_done, 0);
        check("rst_rsp_out", rsp_out, 0);
        check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: 5 - 10 = -5, which gives out = 59 with borrow 1
        req0_valid = 1'b1; req0_a = 6'd5; req0_b = 6'd10; req0_op = 2'b01;
        rsp0_ready = 1'b1;
        #1;
        check("single_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("single_exec_busy", busy, 1);
        check("single_exec_valid", rsp0_valid, 0);
        tick();
        check("single_rsp_valid", rsp0_valid, 1);
        check("single_out", rsp_out, 59);
        check("single_cout", rsp_cout, 1);
        tick();
        check("single_ops_done", ops_done, 1);
        check("single_idle", busy, 0);

        // Reset pulse so that contention starts with prio = 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Contention: req0 computes 15 AND 25 = 9; req1 computes 30 XOR 35 = 61
        req0_valid = 1'b1; req0_a = 6'd15; req0_b = 6'd25; req0_op = 2'b10;
        req1_valid = 1'b1; req1_a = 6'd30; req1_b = 6'd35; req1_op = 2'b11;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        check("cont_ready", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 1'b0;
        check("cont_exec_ready", {req0_ready, req1_ready}, 0);
        tick();
        check("cont_rsp0", {rsp0_valid, rsp1_valid}, 2'b10);
        check("cont_out0", rsp_out, 9);
        check("cont_cout0", rsp_cout, 0);
        tick();
        check("cont_req1_ready", req1_ready, 1);
        check("cont_ops1", ops_done, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("cont_rsp1", {rsp0_valid, rsp1_valid}, 2'b01);
        check("cont_out1", rsp_out, 61);
        check("cont_cout1", rsp_cout, 0);
        tick();
        check("cont_ops2", ops_done, 2);

        // Fairness: req0 computes 63 + 1 = 0 with carry; req1 computes 0 - 1 = 63 with borrow
        req0_valid = 1'b1; req0_a = 6'd63; req0_b = 6'd1; req0_op = 2'b00;
        req1_valid = 1'b1; req1_a = 6'd0;  req1_b = 6'd1; req1_op = 2'b01;
        served = 0;
        for (int cyc = 0; cyc < 60 && served < 6; cyc++) begin
            tick();
            if (rsp0_valid || rsp1_valid) begin
                who = rsp1_valid ? 1 : 0;
                check("fair_excl", rsp0_valid & rsp1_valid, 0);
                check("fair_order", who, served % 2);
                check("fair_out", rsp_out, (who == 1) ? 63 : 0);
                check("fair_cout", rsp_cout, 1);
                served++;
                if (served == 6) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        check("fair_served", served, 6);
        tick();
        check("fair_ops", ops_done, 8);
        check("fair_idle", busy, 0);

        // Backpressure: req1 computes 60 - 3 = 57, and rsp1_ready is held low for 5 cycles
        req1_valid = 1'b1; req1_a = 6'd60; req1_b = 6'd3; req1_op = 2'b01;
        rsp1_ready = 1'b0; rsp0_ready = 1'b1;
        #1;
        check("bp_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 6'd1; req0_b = 6'd1; req0_op = 2'b00;
        check("bp_exec_req0_ready", req0_ready, 0);
        tick();
        check("bp_rsp1", {rsp0_valid, rsp1_valid}, 2'b01);
        check("bp_out", rsp_out, 57);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", rsp1_valid, 1);
            check("bp_hold_out", rsp_out, 57);
            check("bp_hold_cout", rsp_cout, 0);
            check("bp_hold_req0_ready", req0_ready, 0);
            check("bp_hold_ops", ops_done, 8);
        end
        rsp1_ready = 1'b1;
        tick();
        check("bp_done_ops", ops_done, 9);
        check("bp_done_valid", rsp1_valid, 0);
        check("bp_req0_granted", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        check("bp_req0_out", rsp_out, 2);
        tick();
        check("bp_ops10", ops_done, 10);

        // Reset mid-operation: req1 computes 7 + 9, then reset is applied during EXEC
        req1_valid = 1'b1; req1_a = 6'd7; req1_b = 6'd9; req1_op = 2'b00;
        tick();
        req1_valid = 1'b0;
        check("mrst_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out", rsp_out, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ops", ops_done, 0);
        check("mrst_valid", {rsp0_valid, rsp1_valid}, 0);
        tick();
        check("mrst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("mrst_prio", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("mrst_idle", busy, 0);

        // Counter wrap: 256 back-to-back ops, each 63 + 63 = 126, i.e. out 62 with carry
        req0_valid = 1'b1; req0_a = 6'd63; req0_b = 6'd63; req0_op = 2'b00;
        rsp0_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 1000 && n < 256; cyc++) begin
            tick();
            if (rsp0_valid) begin
                n++;
                if (n == 256) begin
                    check("wrap_ops_255", ops_done, 255);
                    check("wrap_out", rsp_out, 62);
                    check("wrap_cout", rsp_cout, 1);
                    req0_valid = 1'b0;
                end
            end
        end
        check("wrap_count", n, 256);
        tick();
        check("wrap_ops_zero", ops_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the team's 6-bit `ALU` between two requesters. Each requester issues an operation over a valid/ready handshake and receives its result over a valid/ready response channel. A three-state FSM sequences capture, execute and response. Fair round-robin arbitration picks the winner when both requesters are pending. The block sits between the two issuing units and the ALU, and the ALU is instantiated inside it.

## Interface
Parameters:
- `W`, 6: operand/result width; must match the `ALU` width.
- `CNT_W`, 8: width of the completed-operation counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request pending.
- `req0_a` / `req1_a`  in  W  operand A.
- `req0_b` / `req1_b`  in  W  operand B.
- `req0_op` / `req1_op`  in  2  ALU op code, passed to `ALU` unchanged.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `rsp0_valid` / `rsp1_valid`  out  1  result available.
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes the result.
- `rsp_out`  out  W  registered ALU result, shared by both response channels.
- `rsp_cout`  out  1  registered ALU carry-out.
- `busy`  out  1  FSM is not in IDLE.
- `ops_done`  out  CNT_W  count of completed response handshakes.

## Operation
State machine: IDLE, EXEC, RESP.

IDLE:
- `grant` is combinational.
  - Only one `reqN_valid` high: that requester wins.
  - Both high: the requester selected by `prio` wins (`prio`=0 selects req0).
- `reqN_ready` = (state==IDLE) & (grant==N) & `rst_n`.
- On `valid & ready`, capture a, b, op and `owner`=N, then go to EXEC.

EXEC:
- The `ALU` sees the captured operands.
- At the edge, register ALU `out`/`cout` into `rsp_out`/`rsp_cout`, then go to RESP.

RESP:
- `rsp<owner>_valid`=1; the other response valid stays 0.
- Hold until `rsp<owner>_ready`=1. At that edge:
  - go to IDLE;
  - set `prio` = ~`owner`, so the last-served requester becomes low priority;
  - increment `ops_done`.

Requester rules:
- Both `reqN_ready` are 0 outside IDLE.
- Requesters hold valid and operands stable until ready. Dropping valid before ready is legal; nothing is captured.
- A non-owner's `rspN_ready` is ignored.

Width and arithmetic:
- The block performs no arithmetic on data. `rsp_out`/`rsp_cout` equal the `ALU` outputs for the captured operands.
- `ops_done` wraps from 2^CNT_W−1 to 0.

Reset values:
- state IDLE, `prio`=0, `owner`=0.
- `rsp_out`=0, `rsp_cout`=0, `rsp0_valid`=`rsp1_valid`=0.
- `busy`=0, `ops_done`=0, both `reqN_ready`=0 while `rst_n` is low.

Reset mid-operation (EXEC or RESP):
- The operation is aborted immediately and no response is produced.
- The requester must reissue it.

## Timing
- Request accepted at edge k: EXEC during cycle k→k+1, result registered at edge k+1, `rspN_valid` high after edge k+1.
- Minimum latency is accept edge to response valid = 1 cycle.
- Minimum request-to-request spacing is 3 cycles, reached when `rsp_ready` is already high.
- `rsp_ready` held low keeps RESP and all result outputs stable indefinitely.
- A request that arrives while `busy` waits. It is granted in the IDLE cycle following the response handshake.
- Simultaneous events:
  - a response handshake and a new valid in the same cycle: the new request is seen one cycle later, in IDLE.
  - both valids high after a req0 completion: req1 wins.
- `busy` is registered: 1 from the edge after accept until the edge of the response handshake.

## Test plan
- Single request: req0 A=5, B=10, op=01, `rsp0_ready`=1. Required: `req0_ready` high in the same cycle; `rsp0_valid` 2 edges later; `rsp_out`/`rsp_cout` equal to a standalone `ALU` reference; `ops_done`=1.
- Contention: both valid from reset (req0 A=15, B=25, op=10; req1 A=30, B=35, op=11). Required: req0 served first, then req1; each result matches the reference ALU; `rsp1_valid` never high during req0's response.
- Fairness: both requesters held continuously valid for 6 operations. Required: strict alternation 0,1,0,1,0,1.
- Backpressure: req1 A=60, B=3, op=01, `rsp1_ready` low for 5 cycles. Required: `rsp1_valid`, `rsp_out` and `rsp_cout` stable; `req0_ready` stays 0 although req0 is valid; completion occurs on the cycle `rsp1_ready` rises.
- Reset mid-operation: drop `rst_n` asynchronously in EXEC. Required: immediately `rsp_out`=0, `busy`=0, `ops_done`=0, no response; after release, req0 has priority.
- Counter wrap: 256 back-to-back operations. Required: `ops_done` returns to 0.
